// File: rtl/painterengine_gpu_dma_reader.sv
// GPU DMA read master: fetches words over AXI4 and streams them to one
// of four routed clients, splitting bursts at 1 KiB address boundaries.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_DATA_ALIGN = 32,
  parameter int PARAM_TIMEOUT    = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,

  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,

  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_ready,

  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,

  output logic [0:0]   o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,

  input  logic [0:0]   i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  typedef enum logic [4:0] {
    ST_ROUTING     = 5'h01,
    ST_PARAM_CHECK = 5'h02,
    ST_CALC        = 5'h03,
    ST_CALC2       = 5'h04,
    ST_CALC3       = 5'h05,
    ST_ADDR        = 5'h06,
    ST_DATA        = 5'h07,
    ST_DONE        = 5'h08,
    ST_ERR_ROUTE   = 5'h11,
    ST_ERR_ALIGN   = 5'h12,
    ST_ERR_LEN     = 5'h13,
    ST_ERR_AR_TO   = 5'h14,
    ST_ERR_R_TO    = 5'h15,
    ST_ERR_RESP    = 5'h16,
    ST_ERR_LAST    = 5'h17
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(PARAM_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] addr_r;
  logic [31:0] len_r;
  logic [31:0] offset;
  logic [7:0]  unalign;
  logic [8:0]  aligned;
  logic [31:0] remain;
  logic [8:0]  burstlen;
  logic [8:0]  beatcnt;
  logic [15:0] tcnt;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;

  logic        route_onehot;
  logic [1:0]  route_idx;
  logic [6:0]  route_base;
  logic [8:0]  blen_c;
  logic [32:0] offset_nx;
  logic        last_beat;
  logic        rready;
  logic        beat;
  logic        unused_ok;

  // Decode the client select into a lane index; flag exactly-one-hot.
  always_comb begin
    route_onehot = 1'b1;
    route_idx    = 2'd0;
    case (i_wire_router)
      4'b0001: route_idx = 2'd0;
      4'b0010: route_idx = 2'd1;
      4'b0100: route_idx = 2'd2;
      4'b1000: route_idx = 2'd3;
      default: route_onehot = 1'b0;
    endcase
  end

  assign route_base = {route_idx, 5'd0};

  // Burst length is the room left in the 1 KiB window or the remaining words.
  always_comb begin
    if ({23'd0, aligned} < remain) begin
      blen_c = aligned;
    end else begin
      blen_c = remain[8:0];
    end
  end

  assign offset_nx = {1'b0, offset} + {24'd0, burstlen};
  assign last_beat = (beatcnt == burstlen - 9'd1);

  assign rready = (state == ST_DATA) & i_wire_data_ready[idx];
  assign beat   = i_wire_M_AXI_RVALID & rready;

  // Beat valid only on the routed lane, suppressed for error responses.
  always_comb begin
    o_wire_data_valid = 4'b0000;
    if (state == ST_DATA) begin
      o_wire_data_valid[idx] = i_wire_M_AXI_RVALID & ~i_wire_M_AXI_RRESP[1];
    end
  end

  // Main sequencer: route, validate, split bursts, move data, trap errors.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state    <= ST_ROUTING;
      idx      <= 2'd0;
      addr_r   <= 32'd0;
      len_r    <= 32'd0;
      offset   <= 32'd0;
      unalign  <= 8'd0;
      aligned  <= 9'd0;
      remain   <= 32'd0;
      burstlen <= 9'd0;
      beatcnt  <= 9'd0;
      tcnt     <= 16'd0;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      arlen    <= 8'd0;
    end else begin
      unique case (state)
        ST_ROUTING: begin
          if (i_wire_router != 4'b0000) begin
            if (route_onehot) begin
              idx    <= route_idx;
              addr_r <= i_wire_address[route_base +: 32];
              len_r  <= i_wire_length[route_base +: 32];
              offset <= 32'd0;
              state  <= ST_PARAM_CHECK;
            end else begin
              state <= ST_ERR_ROUTE;
            end
          end
        end
        ST_PARAM_CHECK: begin
          if (addr_r[1:0] != 2'b00) begin
            state <= ST_ERR_ALIGN;
          end else if (len_r == 32'd0) begin
            state <= ST_ERR_LEN;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          unalign <= addr_r[9:2] + offset[7:0];
          state   <= ST_CALC2;
        end
        ST_CALC2: begin
          aligned <= 9'd256 - {1'b0, unalign};
          remain  <= len_r - offset;
          state   <= ST_CALC3;
        end
        ST_CALC3: begin
          araddr   <= addr_r + {offset[29:0], 2'b00};
          burstlen <= blen_c;
          arlen    <= 8'(blen_c - 9'd1);
          arvalid  <= 1'b1;
          beatcnt  <= 9'd0;
          tcnt     <= 16'd0;
          state    <= ST_ADDR;
        end
        ST_ADDR: begin
          if (i_wire_M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            tcnt    <= 16'd0;
            state   <= ST_DATA;
          end else if (tcnt == TO_LAST) begin
            arvalid <= 1'b0;
            state   <= ST_ERR_AR_TO;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (i_wire_M_AXI_RVALID) begin
            if (beat) begin
              tcnt <= 16'd0;
              if (i_wire_M_AXI_RRESP[1]) begin
                state <= ST_ERR_RESP;
              end else if (i_wire_M_AXI_RLAST != last_beat) begin
                state <= ST_ERR_LAST;
              end else if (last_beat) begin
                offset <= offset_nx[31:0];
                if (offset_nx >= {1'b0, len_r}) begin
                  state <= ST_DONE;
                end else begin
                  state <= ST_CALC;
                end
              end else begin
                beatcnt <= beatcnt + 9'd1;
              end
            end
          end else if (tcnt == TO_LAST) begin
            state <= ST_ERR_R_TO;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign o_wire_data          = {4{i_wire_M_AXI_RDATA}};
  assign o_wire_M_AXI_RREADY  = rready;
  assign o_wire_done          = (state == ST_DONE);
  assign o_wire_error         = state[4];
  assign o_wire_error_type    = state[4] ? state[2:0] : 3'd0;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr;
  assign o_wire_M_AXI_ARLEN   = arlen;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = arvalid;

  assign unused_ok = ^{i_wire_M_AXI_RID, 32'(PARAM_DATA_ALIGN)};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the GPU DMA reader: table-driven transfers with a
// scoreboard for AR requests and delivered words, plus fault sequences.
module tb_painterengine_gpu_dma_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   router;
  logic [127:0] addr_bus;
  logic [127:0] len_bus;
  logic [127:0] data;
  logic [3:0]   dv;
  logic [3:0]   data_ready;
  logic         done;
  logic         error;
  logic [2:0]   etype;
  logic [0:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arqos;
  logic         arvalid;
  logic         arready;
  logic [0:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader #(
    .PARAM_DATA_ALIGN(32),
    .PARAM_TIMEOUT(256)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(rst_n),
    .i_wire_router(router),
    .i_wire_address(addr_bus),
    .i_wire_length(len_bus),
    .o_wire_data(data),
    .o_wire_data_valid(dv),
    .i_wire_data_ready(data_ready),
    .o_wire_done(done),
    .o_wire_error(error),
    .o_wire_error_type(etype),
    .o_wire_M_AXI_ARID(arid),
    .o_wire_M_AXI_ARADDR(araddr),
    .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize),
    .o_wire_M_AXI_ARBURST(arburst),
    .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache),
    .o_wire_M_AXI_ARPROT(arprot),
    .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid),
    .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid),
    .i_wire_M_AXI_RDATA(rdata),
    .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast),
    .i_wire_M_AXI_RVALID(rvalid),
    .o_wire_M_AXI_RREADY(rready)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] data_q[$];
  logic [39:0] ar_q[$];

  logic [3:0]   s_dv;
  logic [127:0] s_data;
  logic         s_rready;

  typedef struct {
    logic [3:0]  router;
    logic [31:0] addr;
    logic [31:0] len;
    int          nb;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    bit          tog;
  } vec_t;

  typedef struct {
    logic [3:0]  router;
    logic [31:0] addr;
    logic [31:0] len;
    logic [2:0]  et;
  } err_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[9:2], 24'h0};
  endfunction

  function automatic int lane_of(input logic [3:0] r);
    int l;
    l = 0;
    for (int k = 0; k < 4; k++) if (r[k]) l = k;
    return l;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ar"}, {arvalid, araddr, arlen}, 0);
    chk({tag, "_r"}, {rready, dv}, 0);
    chk({tag, "_status"}, {done, error, etype}, 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    router     = '0;
    addr_bus   = '0;
    len_bus    = '0;
    data_ready = '0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    rresp      = '0;
    rlast      = 1'b0;
    rid        = '0;
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply(input logic [3:0] r, input logic [31:0] a,
                       input logic [31:0] l);
    int ln;
    ln = lane_of(r);
    router = r;
    addr_bus = '0;
    len_bus = '0;
    addr_bus[ln*32 +: 32] = a;
    len_bus[ln*32 +: 32] = l;
  endtask

  task automatic wait_ar(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      cyc++;
    end while (!arvalid && cyc < 300);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last,
                            input logic [1:0] resp, input logic [3:0] rdy);
    @(negedge clk);
    rvalid     = 1'b1;
    rdata      = d;
    rlast      = last;
    rresp      = resp;
    data_ready = rdy;
    #1;
    s_dv     = dv;
    s_data   = data;
    s_rready = rready;
  endtask

  task automatic start_xfer(input logic [3:0] r, input logic [31:0] a,
                            input logic [31:0] l);
    int cyc;
    do_reset();
    apply(r, a, l);
    wait_ar(cyc);
    chk("arvalid_seen", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lane, cyc, n, i, tc;
    logic [39:0] e;
    logic [31:0] a, ew;
    logic [3:0]  rdy;
    lane = lane_of(v.router);
    ar_q.push_back({v.a0, v.l0});
    if (v.nb == 2) ar_q.push_back({v.a1, v.l1});
    for (int k = 0; k < int'(v.len); k++)
      data_q.push_back(mem(v.addr + 32'(4 * k)));
    do_reset();
    apply(v.router, v.addr, v.len);
    for (int b = 0; b < v.nb; b++) begin
      wait_ar(cyc);
      chk(b == 0 ? "ar_latency" : "rearm_latency", cyc, b == 0 ? 5 : 4);
      if (!arvalid) begin
        ar_q.delete();
        data_q.delete();
        return;
      end
      e = ar_q.pop_front();
      chk("araddr", araddr, e[39:8]);
      chk("arlen", arlen, e[7:0]);
      if (b == 0) begin
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arcache", arcache, 4'b0010);
        chk("ar_zero_fields", {arid, arlock, arprot, arqos}, 0);
      end
      a = araddr;
      n = int'(arlen) + 1;
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("arvalid_drop", arvalid, 1'b0);
      i  = 0;
      tc = 0;
      while (i < n && tc < 2000) begin
        tc++;
        rdy = '0;
        if (!v.tog || tc[0]) rdy[lane] = 1'b1;
        drive_beat(mem(a + 32'(4 * i)), i == n - 1, 2'b00, rdy);
        chk("rready_track", s_rready, rdy[lane]);
        chk("lane_valid", s_dv, 4'b0001 << lane);
        if (s_rready) begin
          ew = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEAD_BEEF;
          chk("rdata", s_data[lane*32 +: 32], ew);
          i++;
        end
      end
      if (i < n) chk("beats_delivered", i, n);
    end
    tc = 0;
    while (!done && !error && tc < 20) begin
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      tc++;
    end
    chk("done", done, 1'b1);
    chk("no_error", {error, etype}, 0);
    chk("sb_empty", data_q.size() + ar_q.size(), 0);
    data_q.delete();
    ar_q.delete();
  endtask

  task automatic run_err(input err_t t);
    logic seen;
    do_reset();
    apply(t.router, t.addr, t.len);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen |= arvalid;
    end
    chk("param_err_type", etype, t.et);
    chk("param_err_flag", error, 1'b1);
    chk("param_err_no_arvalid", seen, 1'b0);
  endtask

  vec_t vt[4];
  err_t et[3];

  initial begin
    int cnt;
    vt[0] = '{4'b0001, 32'h1000, 32'd4,   1, 32'h1000, 8'd3,   32'h0,   8'd0, 1'b0};
    vt[1] = '{4'b0010, 32'h0,    32'd300, 2, 32'h0,    8'd255, 32'h400, 8'd43, 1'b0};
    vt[2] = '{4'b0100, 32'h3F0,  32'd10,  2, 32'h3F0,  8'd3,   32'h400, 8'd5, 1'b1};
    vt[3] = '{4'b1000, 32'h7FC,  32'd3,   2, 32'h7FC,  8'd0,   32'h800, 8'd1, 1'b0};
    et[0] = '{4'b0011, 32'h1000, 32'd4, 3'd1};
    et[1] = '{4'b0001, 32'h1002, 32'd4, 3'd2};
    et[2] = '{4'b0100, 32'h2000, 32'd0, 3'd3};

    for (int v = 0; v < 4; v++) run_vec(vt[v]);
    for (int k = 0; k < 3; k++) run_err(et[k]);

    do_reset();
    apply(4'b0001, 32'h100, 32'd4);
    wait_ar(cnt);
    chk("ar_to_arvalid", arvalid, 1'b1);
    cnt = 0;
    while (!error && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("ar_timeout_cycles", cnt, 256);
    chk("ar_timeout_type", etype, 3'd4);

    start_xfer(4'b0001, 32'h0, 32'd4);
    cnt = 0;
    while (!error && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("r_timeout_cycles", cnt, 256);
    chk("r_timeout_type", etype, 3'd5);

    start_xfer(4'b0010, 32'h200, 32'd1);
    for (int k = 0; k < 300; k++)
      drive_beat(mem(32'h200), 1'b1, 2'b00, 4'b0000);
    chk("backpressure_no_timeout", error, 1'b0);
    chk("backpressure_rready", s_rready, 1'b0);
    drive_beat(mem(32'h200), 1'b1, 2'b00, 4'b0010);
    chk("backpressure_lane", s_dv, 4'b0010);
    chk("backpressure_data", s_data[63:32], mem(32'h200));
    @(negedge clk);
    rvalid = 1'b0;
    chk("backpressure_done", done, 1'b1);

    start_xfer(4'b0001, 32'h40, 32'd4);
    drive_beat(mem(32'h40), 1'b0, 2'b00, 4'b0001);
    drive_beat(mem(32'h44), 1'b0, 2'b10, 4'b0001);
    chk("resp_lane_valid", s_dv, 4'b0000);
    @(negedge clk);
    rvalid = 1'b0;
    chk("resp_err_type", etype, 3'd6);

    start_xfer(4'b0001, 32'h80, 32'd4);
    drive_beat(mem(32'h80), 1'b0, 2'b00, 4'b0001);
    drive_beat(mem(32'h84), 1'b0, 2'b00, 4'b0001);
    drive_beat(mem(32'h88), 1'b1, 2'b00, 4'b0001);
    @(negedge clk);
    rvalid = 1'b0;
    chk("last_err_type", etype, 3'd7);
    chk("last_err_not_done", done, 1'b0);

    start_xfer(4'b0100, 32'h300, 32'd8);
    drive_beat(mem(32'h300), 1'b0, 2'b00, 4'b0100);
    @(negedge clk);
    rvalid     = 1'b1;
    data_ready = 4'b0100;
    #1;
    chk("pre_reset_active", {rready, dv}, {1'b1, 4'b0100});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
